aq_djpeg_bitbuf: RTL and testbench

Parametrised successor to the entropy-stage bit register.
- Accepts packed JPEG stream words and unpacks them to bytes.
- In image mode, removes FF00 byte stuffing and FF fill bytes, and detects markers (RSTn, EOI, others) as explicit events.
- Presents an MSB-aligned peek window of OUT_WIDTH bits to the Huffman decoder, which consumes a variable number of bits per cycle.
- Sits between the AXI-stream input adapter and the Huffman/header parsers.

---
 rtl/aq_djpeg_bitbuf.sv | 199 +++++++++++++++++++
 tb/tb_aq_djpeg_bitbuf.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aq_djpeg_bitbuf.sv
// aq_djpeg_bitbuf: JPEG entropy-stage bit buffer.
// Unpacks stream words to bytes, removes FF00 stuffing and FF fill bytes in
// image mode, reports markers/EOI as events, and presents an MSB-aligned peek
// window of OUT_WIDTH bits from which a variable number of bits is consumed.
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   in_data/valid/ready stream word input (byte order set by BYTE_SWAP)
//   image_en           1 = entropy-coded segment, 0 = header (raw bytes)
//   out_data/valid     peek window (MSB = oldest bit, pad bits are 1)
//   out_end            EOI seen
//   use_en/use_width   consume use_width bits this cycle
//   align_byte         discard bits down to a byte boundary
//   marker_valid/code  pending marker and its second byte
//   marker_ack         release pending marker
//   fill_level         valid bits held in the accumulator
module aq_djpeg_bitbuf #(
    parameter int unsigned IN_BYTES  = 4,
    parameter int unsigned OUT_WIDTH = 32,
    parameter int unsigned BUF_BITS  = 96,
    parameter int unsigned BYTE_SWAP = 0
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [IN_BYTES*8-1:0]           in_data,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic                            image_en,
    output logic [OUT_WIDTH-1:0]            out_data,
    output logic                            out_valid,
    output logic                            out_end,
    input  logic                            use_en,
    input  logic [$clog2(OUT_WIDTH+1)-1:0]  use_width,
    input  logic                            align_byte,
    output logic                            marker_valid,
    output logic [7:0]                      marker_code,
    input  logic                            marker_ack,
    output logic [$clog2(BUF_BITS+1)-1:0]   fill_level
);

    localparam int unsigned IN_W = IN_BYTES * 8;
    localparam int unsigned FW   = $clog2(BUF_BITS + 1);
    localparam int unsigned CW   = $clog2(IN_BYTES + 1);

    typedef enum logic [1:0] {
        sPass       = 2'd0,
        sSeenFf     = 2'd1,
        sMarkerHold = 2'd2,
        sEnd        = 2'd3
    } stateT;

    stateT               state;
    stateT               nextState;
    logic [IN_W-1:0]     wordReg;
    logic [IN_W-1:0]     wordNext;
    logic [CW-1:0]       bytesLeft;
    logic [CW-1:0]       bytesLeftNext;
    logic [BUF_BITS-1:0] acc;
    logic [BUF_BITS-1:0] accNext;
    logic [FW-1:0]       fill;
    logic [FW-1:0]       fillNext;
    logic [7:0]          markerCode;
    logic [7:0]          markerCodeNext;

    logic [7:0]          curByte;
    logic [7:0]          pushByte;
    logic [FW-1:0]       consumed;
    logic [FW-1:0]       fillAfterUse;
    logic                outValidC;
    logic                take;
    logic                push;
    logic                flush;
    logic                inReadyC;

    // Window is valid when full, or when draining the tail before a marker/EOI
    assign outValidC = (fill >= FW'(OUT_WIDTH)) ||
                       (((state == sEnd) || (state == sMarkerHold)) && (fill != '0));

    // Next-state, unstuffing, unpacker and accumulator update
    always_comb begin
        nextState      = state;
        wordNext       = wordReg;
        bytesLeftNext  = bytesLeft;
        markerCodeNext = markerCode;
        consumed       = '0;
        push           = 1'b0;
        flush          = 1'b0;
        take           = 1'b0;
        inReadyC       = 1'b0;

        if (BYTE_SWAP != 0) curByte = wordReg[7:0];
        else                curByte = wordReg[IN_W-1 -: 8];
        pushByte = curByte;

        // use_en wins over align_byte; an over-wide request clamps to fill
        if (use_en && outValidC) begin
            if (FW'(use_width) > fill) consumed = fill;
            else                       consumed = FW'(use_width);
        end else if (align_byte) begin
            consumed = fill & FW'(7);
        end
        fillAfterUse = fill - consumed;

        take = (bytesLeft != '0) &&
               ((state == sPass) || (state == sSeenFf)) &&
               (fillAfterUse <= FW'(BUF_BITS - 8));

        if ((state == sEnd) && !image_en) begin
            flush     = 1'b1;
            nextState = sPass;
        end else if (take) begin
            if (!image_en) begin
                push      = 1'b1;
                nextState = sPass;
            end else begin
                unique case (state)
                    sPass: begin
                        if (curByte == 8'hFF) nextState = sSeenFf;
                        else                  push      = 1'b1;
                    end
                    sSeenFf: begin
                        if (curByte == 8'h00) begin
                            push      = 1'b1;
                            pushByte  = 8'hFF;
                            nextState = sPass;
                        end else if (curByte == 8'hFF) begin
                            nextState = sSeenFf;
                        end else if (curByte == 8'hD9) begin
                            nextState = sEnd;
                        end else begin
                            markerCodeNext = curByte;
                            nextState      = sMarkerHold;
                        end
                    end
                    default: nextState = state;
                endcase
            end
        end else if ((state == sMarkerHold) && marker_ack) begin
            nextState = sPass;
        end

        // A new word may load in the same cycle the last byte leaves
        inReadyC = !rst && ((state == sPass) || (state == sSeenFf)) &&
                   ((bytesLeft == '0) || ((bytesLeft == CW'(1)) && take));

        if (flush) begin
            bytesLeftNext = '0;
        end else if (in_valid && inReadyC) begin
            wordNext      = in_data;
            bytesLeftNext = CW'(IN_BYTES);
        end else if (take) begin
            if (BYTE_SWAP != 0) wordNext = wordReg >> 8;
            else                wordNext = wordReg << 8;
            bytesLeftNext = bytesLeft - CW'(1);
        end

        // Bits below fill stay zero, so a pushed byte can simply be OR-ed in
        accNext  = acc << consumed;
        fillNext = fillAfterUse;
        if (push) begin
            accNext  = accNext | ({pushByte, {(BUF_BITS-8){1'b0}}} >> fillAfterUse);
            fillNext = fillAfterUse + FW'(8);
        end
        if (flush) begin
            accNext  = '0;
            fillNext = '0;
        end
    end

    // State registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= sPass;
            wordReg    <= '0;
            bytesLeft  <= '0;
            acc        <= '0;
            fill       <= '0;
            markerCode <= '0;
        end else begin
            state      <= nextState;
            wordReg    <= wordNext;
            bytesLeft  <= bytesLeftNext;
            acc        <= accNext;
            fill       <= fillNext;
            markerCode <= markerCodeNext;
        end
    end

    assign in_ready     = inReadyC;
    assign out_valid    = outValidC;
    assign out_end      = (state == sEnd);
    assign marker_valid = (state == sMarkerHold);
    assign marker_code  = markerCode;
    assign fill_level   = fill;
    // Positions beyond fill read as 1 (JPEG pad); an empty buffer reads 0
    assign out_data     = (fill == '0) ? '0 :
                          (acc[BUF_BITS-1 -: OUT_WIDTH] | ({OUT_WIDTH{1'b1}} >> fill));

endmodule

// File: tb/tb_aq_djpeg_bitbuf.sv
// Directed bench for aq_djpeg_bitbuf with default parameters.
module tb_aq_djpeg_bitbuf;

    localparam int unsigned IN_BYTES  = 4;
    localparam int unsigned OUT_WIDTH = 32;
    localparam int unsigned BUF_BITS  = 96;
    localparam int unsigned UW        = $clog2(OUT_WIDTH + 1);
    localparam int unsigned FW        = $clog2(BUF_BITS + 1);

    logic                  clk = 1'b0;
    logic                  rst;
    logic [IN_BYTES*8-1:0] in_data;
    logic                  in_valid;
    logic                  in_ready;
    logic                  image_en;
    logic [OUT_WIDTH-1:0]  out_data;
    logic                  out_valid;
    logic                  out_end;
    logic                  use_en;
    logic [UW-1:0]         use_width;
    logic                  align_byte;
    logic                  marker_valid;
    logic [7:0]            marker_code;
    logic                  marker_ack;
    logic [FW-1:0]         fill_level;

    int vectors     = 0;
    int miscompares = 0;

    aq_djpeg_bitbuf #(
        .IN_BYTES (IN_BYTES),
        .OUT_WIDTH(OUT_WIDTH),
        .BUF_BITS (BUF_BITS),
        .BYTE_SWAP(0)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .image_en    (image_en),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_end     (out_end),
        .use_en      (use_en),
        .use_width   (use_width),
        .align_byte  (align_byte),
        .marker_valid(marker_valid),
        .marker_code (marker_code),
        .marker_ack  (marker_ack),
        .fill_level  (fill_level)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic sendWord(input logic [31:0] w);
        int n;
        @(negedge clk);
        in_data  = w;
        in_valid = 1'b1;
        #1;
        n = 0;
        while (in_ready !== 1'b1 && n < 64) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (in_ready !== 1'b1) check("in_ready_timeout", 64'(in_ready), 64'(1));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        #1;
    endtask

    task automatic consume(input int w);
        @(negedge clk);
        use_en    = 1'b1;
        use_width = UW'(w);
        @(negedge clk);
        use_en    = 1'b0;
        use_width = '0;
        #1;
    endtask

    task automatic alignPulse();
        @(negedge clk);
        align_byte = 1'b1;
        @(negedge clk);
        align_byte = 1'b0;
        #1;
    endtask

    task automatic ackPulse();
        @(negedge clk);
        marker_ack = 1'b1;
        @(negedge clk);
        marker_ack = 1'b0;
        #1;
    endtask

    task automatic resetDut();
        @(negedge clk);
        rst      = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst        = 1'b1;
        in_data    = '0;
        in_valid   = 1'b0;
        image_en   = 1'b0;
        use_en     = 1'b0;
        use_width  = '0;
        align_byte = 1'b0;
        marker_ack = 1'b0;

        // Reset state, observed while rst is still high
        @(negedge clk);
        @(negedge clk);
        #1;
        check("rst_in_ready",     64'(in_ready),     64'(0));
        check("rst_out_data",     64'(out_data),     64'(0));
        check("rst_out_valid",    64'(out_valid),    64'(0));
        check("rst_out_end",      64'(out_end),      64'(0));
        check("rst_marker_valid", 64'(marker_valid), 64'(0));
        check("rst_marker_code",  64'(marker_code),  64'(0));
        check("rst_fill",         64'(fill_level),   64'(0));
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", 64'(in_ready), 64'(1));

        // 1: header mode, latency to a full window
        sendWord(32'h12345678);
        idle(3);
        check("t1_fill_n4",  64'(fill_level), 64'(24));
        check("t1_valid_n4", 64'(out_valid),  64'(0));
        idle(1);
        check("t1_fill",  64'(fill_level), 64'(32));
        check("t1_data",  64'(out_data),   64'(32'h12345678));
        check("t1_valid", 64'(out_valid),  64'(1));

        // 2: unstuffing inside a word
        resetDut();
        image_en = 1'b1;
        sendWord(32'hAAFF00BB);
        sendWord(32'hCCDDEEFF);
        idle(10);
        check("t2_fill",  64'(fill_level), 64'(48));
        check("t2_data",  64'(out_data),   64'(32'hAAFFBBCC));
        check("t2_valid", 64'(out_valid),  64'(1));

        // 3: FF at end of word, 00 at start of next
        resetDut();
        sendWord(32'h112233FF);
        sendWord(32'h00445566);
        idle(10);
        check("t3_fill", 64'(fill_level), 64'(56));
        check("t3_data", 64'(out_data),   64'(32'h112233FF));
        consume(32);
        check("t3_fill2",  64'(fill_level), 64'(24));
        check("t3_data2",  64'(out_data),   64'(32'h445566FF));
        check("t3_valid2", 64'(out_valid),  64'(0));

        // 4: marker with bits still buffered
        resetDut();
        sendWord(32'hAB55FFD3);
        idle(8);
        check("t4_mvalid",   64'(marker_valid), 64'(1));
        check("t4_mcode",    64'(marker_code),  64'(8'hD3));
        check("t4_in_ready", 64'(in_ready),     64'(0));
        check("t4_fill",     64'(fill_level),   64'(16));
        check("t4_valid",    64'(out_valid),    64'(1));
        check("t4_data",     64'(out_data),     64'(32'hAB55FFFF));
        consume(13);
        check("t4_fill3", 64'(fill_level), 64'(3));
        check("t4_data3", 64'(out_data),   64'(32'hBFFFFFFF));
        alignPulse();
        check("t4_fill_al",  64'(fill_level),   64'(0));
        check("t4_valid_al", 64'(out_valid),    64'(0));
        check("t4_mheld",    64'(marker_valid), 64'(1));
        ackPulse();
        check("t4_mvalid_ack", 64'(marker_valid), 64'(0));
        check("t4_ready_ack",  64'(in_ready),     64'(1));
        check("t4_fill_ack",   64'(fill_level),   64'(0));

        // 5: EOI with one byte left to drain
        resetDut();
        sendWord(32'h119AFFD9);
        idle(8);
        check("t5_end",   64'(out_end),    64'(1));
        check("t5_fill0", 64'(fill_level), 64'(16));
        consume(8);
        check("t5_fill",  64'(fill_level), 64'(8));
        check("t5_valid", 64'(out_valid),  64'(1));
        check("t5_data",  64'(out_data),   64'(32'h9AFFFFFF));
        consume(8);
        check("t5_fill_e",  64'(fill_level), 64'(0));
        check("t5_valid_e", 64'(out_valid),  64'(0));
        check("t5_end_e",   64'(out_end),    64'(1));
        image_en = 1'b0;
        idle(1);
        check("t5_end_clr",   64'(out_end),  64'(0));
        check("t5_ready_clr", 64'(in_ready), 64'(1));

        // 6: consume clamp, align, reset mid-stream
        resetDut();
        image_en = 1'b1;
        sendWord(32'h01020304);
        sendWord(32'h05FFD9EE);
        idle(10);
        check("t6_end",  64'(out_end),    64'(1));
        check("t6_fill", 64'(fill_level), 64'(40));
        consume(13);
        check("t6_fill27", 64'(fill_level), 64'(27));
        check("t6_data27", 64'(out_data),   64'(32'h406080BF));
        alignPulse();
        check("t6_fill24", 64'(fill_level), 64'(24));
        check("t6_data24", 64'(out_data),   64'(32'h030405FF));
        consume(32);
        check("t6_clamp",  64'(fill_level), 64'(0));
        check("t6_valid0", 64'(out_valid),  64'(0));
        image_en = 1'b0;
        idle(1);
        sendWord(32'hDEADBEEF);
        idle(2);
        check("t6_fill_mid", 64'(fill_level), 64'(16));
        @(negedge clk);
        rst       = 1'b1;
        in_valid  = 1'b1;
        in_data   = 32'hCAFEF00D;
        use_en    = 1'b1;
        use_width = UW'(5);
        @(negedge clk);
        #1;
        check("t6_rst_fill",   64'(fill_level),   64'(0));
        check("t6_rst_data",   64'(out_data),     64'(0));
        check("t6_rst_valid",  64'(out_valid),    64'(0));
        check("t6_rst_end",    64'(out_end),      64'(0));
        check("t6_rst_marker", 64'(marker_valid), 64'(0));
        check("t6_rst_ready",  64'(in_ready),     64'(0));
        rst       = 1'b0;
        in_valid  = 1'b0;
        use_en    = 1'b0;
        use_width = '0;
        idle(1);

        // 7: full accumulator stalls the unpacker without losing data
        resetDut();
        image_en = 1'b0;
        sendWord(32'h00112233);
        sendWord(32'h44556677);
        sendWord(32'h8899AABB);
        sendWord(32'hCCDDEEFF);
        idle(4);
        check("t7_full",     64'(fill_level), 64'(96));
        check("t7_stall_rdy", 64'(in_ready),  64'(0));
        check("t7_data0",    64'(out_data),   64'(32'h00112233));
        consume(32);
        check("t7_fill72", 64'(fill_level), 64'(72));
        idle(4);
        check("t7_refull", 64'(fill_level), 64'(96));
        check("t7_data1",  64'(out_data),   64'(32'h44556677));
        consume(32);
        check("t7_fill64", 64'(fill_level), 64'(64));
        check("t7_data2",  64'(out_data),   64'(32'h8899AABB));
        consume(32);
        check("t7_data3", 64'(out_data), 64'(32'hCCDDEEFF));
        consume(32);
        check("t7_empty", 64'(fill_level), 64'(0));
        check("t7_ready", 64'(in_ready),   64'(1));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
